seg_scan_disp: RTL and testbench

Downstream display stage for the counting game top level. It captures up to two game values (0..99) and a level code, and converts them to BCD with an iterative shift-add-3 converter. It then time-multiplexes the results onto the 8-digit 7-segment display (seg/dig), with leading-zero blanking, out-of-range indication and per-field blinking. It is driven by the game FSM (score/countdown/random number) through a load/done handshake.

---
 rtl/seg_scan_disp_if.sv | 29 ++
 rtl/seg_scan_disp.sv | 197 +++++++++++++++++++
 tb/tb_seg_scan_disp.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_disp_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg_scan_disp_if                                                           |
// | Load/done handshake, field inputs and 7-segment scan outputs.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface seg_scan_disp_if;
    logic       load;
    logic [6:0] val_a;
    logic [6:0] val_b;
    logic [1:0] lvl;
    logic       blink_a;
    logic       blink_b;
    logic       busy;
    logic       done;
    logic [7:0] seg;
    logic [7:0] dig;

    modport master (
        output load, val_a, val_b, lvl, blink_a, blink_b,
        input  busy, done, seg, dig
    );

    modport slave (
        input  load, val_a, val_b, lvl, blink_a, blink_b,
        output busy, done, seg, dig
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_disp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg_scan_disp                                                              |
// | Captures two 0..99 values and a level code, converts to BCD by iterative   |
// | shift-add-3 and scans them onto an 8-digit 7-segment display.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seg_scan_disp #(
    parameter int CLK_HZ   = 100000000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 2
) (
    input  logic           clk,
    input  logic           rst,
    seg_scan_disp_if.slave bus
);

    localparam int c_SCAN_DIV  = CLK_HZ / SCAN_HZ;
    localparam int c_BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int c_SCAN_W    = $clog2(c_SCAN_DIV + 1);
    localparam int c_BLINK_W   = $clog2(c_BLINK_DIV + 1);
    localparam logic [c_SCAN_W-1:0]  c_SCAN_LAST  = c_SCAN_W'(c_SCAN_DIV - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(c_BLINK_DIV - 1);
    localparam logic [7:0] c_BLANK = 8'h00;
    localparam logic [7:0] c_DASH  = 8'h40;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    function automatic logic [7:0] f_seg(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'h3F;
            4'd1:    s = 8'h06;
            4'd2:    s = 8'h5B;
            4'd3:    s = 8'h4F;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'h6D;
            4'd6:    s = 8'h7D;
            4'd7:    s = 8'h07;
            4'd8:    s = 8'h7F;
            4'd9:    s = 8'h6F;
            default: s = c_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] f_add3(input logic [7:0] b);
        logic [7:0] r;
        r[3:0] = (b[3:0] >= 4'd5) ? b[3:0] + 4'd3 : b[3:0];
        r[7:4] = (b[7:4] >= 4'd5) ? b[7:4] + 4'd3 : b[7:4];
        return r;
    endfunction

    state_t     r_state;
    logic [6:0] r_bin_a, r_bin_b;
    logic [7:0] r_bcd_a, r_bcd_b;
    logic       r_oor_a, r_oor_b;
    logic [1:0] r_lvl;
    logic [2:0] r_iter;
    logic       r_busy, r_done;
    logic [7:0] r_d0, r_d1, r_d4, r_d5, r_d7;

    logic [c_SCAN_W-1:0]  r_scan_cnt;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic [2:0]           r_idx;
    logic                 r_blink_on;
    logic [7:0]           r_seg, r_dig;

    logic [14:0] w_step_a, w_step_b;
    logic [7:0]  w_a0, w_a1, w_b0, w_b1, w_lv;
    logic [7:0]  w_seg_sel;

    // One double-dabble iteration: adjust BCD nibbles, then shift {bcd,bin} left
    assign w_step_a = {f_add3(r_bcd_a), r_bin_a} << 1;
    assign w_step_b = {f_add3(r_bcd_b), r_bin_b} << 1;

    // Ones digit sits on the lower (rightward) enable of each field
    assign w_a0 = r_oor_a ? c_DASH : f_seg(w_step_a[10:7]);
    assign w_a1 = r_oor_a ? c_DASH :
                  (w_step_a[14:11] == 4'd0) ? c_BLANK : f_seg(w_step_a[14:11]);
    assign w_b0 = r_oor_b ? c_DASH : f_seg(w_step_b[10:7]);
    assign w_b1 = r_oor_b ? c_DASH :
                  (w_step_b[14:11] == 4'd0) ? c_BLANK : f_seg(w_step_b[14:11]);
    assign w_lv = (r_lvl == 2'd0) ? c_BLANK : f_seg({2'b00, r_lvl});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_bin_a <= '0;
            r_bin_b <= '0;
            r_bcd_a <= '0;
            r_bcd_b <= '0;
            r_oor_a <= 1'b0;
            r_oor_b <= 1'b0;
            r_lvl   <= '0;
            r_iter  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_d0    <= c_BLANK;
            r_d1    <= c_BLANK;
            r_d4    <= c_BLANK;
            r_d5    <= c_BLANK;
            r_d7    <= c_BLANK;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_COMMIT: begin
                    r_state <= S_IDLE;
                    if (bus.load) begin
                        r_bin_a <= bus.val_a;
                        r_bin_b <= bus.val_b;
                        r_bcd_a <= '0;
                        r_bcd_b <= '0;
                        r_oor_a <= (bus.val_a >= 7'd100);
                        r_oor_b <= (bus.val_b >= 7'd100);
                        r_lvl   <= bus.lvl;
                        r_iter  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_bin_a <= w_step_a[6:0];
                    r_bcd_a <= w_step_a[14:7];
                    r_bin_b <= w_step_b[6:0];
                    r_bcd_b <= w_step_b[14:7];
                    r_iter  <= r_iter + 3'd1;
                    // Last iteration: publish digits straight from the final step
                    if (r_iter == 3'd6) begin
                        r_d0    <= w_a0;
                        r_d1    <= w_a1;
                        r_d4    <= w_b0;
                        r_d5    <= w_b1;
                        r_d7    <= w_lv;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_COMMIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_seg_sel = c_BLANK;
        case (r_idx)
            3'd0:    w_seg_sel = r_d0;
            3'd1:    w_seg_sel = r_d1;
            3'd4:    w_seg_sel = r_d4;
            3'd5:    w_seg_sel = r_d5;
            3'd7:    w_seg_sel = r_d7;
            default: w_seg_sel = c_BLANK;
        endcase
        if (!r_blink_on && bus.blink_a && (r_idx == 3'd0 || r_idx == 3'd1))
            w_seg_sel = c_BLANK;
        if (!r_blink_on && bus.blink_b && (r_idx == 3'd4 || r_idx == 3'd5))
            w_seg_sel = c_BLANK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt  <= '0;
            r_blink_cnt <= '0;
            r_idx       <= '0;
            r_blink_on  <= 1'b1;
            r_seg       <= c_BLANK;
            r_dig       <= 8'hFF;
        end else begin
            if (r_scan_cnt == c_SCAN_LAST) begin
                r_scan_cnt <= '0;
                r_idx      <= r_idx + 3'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            if (r_blink_cnt == c_BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
            r_dig <= ~(8'b1 << r_idx);
            r_seg <= w_seg_sel;
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.seg  = r_seg;
    assign bus.dig  = r_dig;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_disp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seg_scan_disp                                                           |
// | Directed self-checking bench for seg_scan_disp.                            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_seg_scan_disp;

    logic       clk = 1'b0;
    logic       rst;
    int         total = 0;
    int         bad   = 0;
    logic [7:0] cap [8];

    seg_scan_disp_if bus ();
    seg_scan_disp_if bus_blk ();

    seg_scan_disp #(.CLK_HZ(16), .SCAN_HZ(4), .BLINK_HZ(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // With a 16-cycle blink period each digit always lands in the same blink
    // phase of the 32-cycle frame; a 24-cycle period makes blinking observable.
    seg_scan_disp #(.CLK_HZ(24), .SCAN_HZ(6), .BLINK_HZ(1)) dut_blk (
        .clk (clk),
        .rst (rst),
        .bus (bus_blk)
    );

    assign bus_blk.load    = bus.load;
    assign bus_blk.val_a   = bus.val_a;
    assign bus_blk.val_b   = bus.val_b;
    assign bus_blk.lvl     = bus.lvl;
    assign bus_blk.blink_a = bus.blink_a;
    assign bus_blk.blink_b = bus.blink_b;

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the sample point of cycle N+1 for a load in cycle N
    task automatic do_load(input logic [6:0] a, input logic [6:0] b, input logic [1:0] l);
        bus.val_a = a;
        bus.val_b = b;
        bus.lvl   = l;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
    endtask

    task automatic wait_done(input int budget, output logic seen);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        seen = (bus.done === 1'b1);
        tick();
    endtask

    task automatic capture;
        logic [7:0] sel;
        for (int i = 0; i < 8; i++) cap[i] = 8'hEE;
        repeat (40) begin
            tick();
            for (int i = 0; i < 8; i++) begin
                sel = ~(8'b1 << i);
                if (bus.dig === sel) cap[i] = bus.seg;
            end
        end
    endtask

    task automatic test_reset;
        logic [7:0] exp_dig;
        rst = 1'b1;
        bus.load = 1'b0; bus.val_a = '0; bus.val_b = '0; bus.lvl = '0;
        bus.blink_a = 1'b0; bus.blink_b = 1'b0;
        repeat (3) begin
            tick();
            total += 4;
            if (bus.dig !== 8'hFF) begin bad++; $display("FAIL reset_dig got=%h exp=ff", bus.dig); end
            if (bus.seg !== 8'h00) begin bad++; $display("FAIL reset_seg got=%h exp=00", bus.seg); end
            if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
            if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        end
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_dig = ~(8'b1 << (((k - 1) / 4) % 8));
            total += 4;
            if (bus.dig !== exp_dig) begin bad++; $display("FAIL scan_dig k=%0d got=%h exp=%h", k, bus.dig, exp_dig); end
            if (bus.seg !== 8'h00) begin bad++; $display("FAIL scan_blank k=%0d got=%h exp=00", k, bus.seg); end
            if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy k=%0d got=%b exp=0", k, bus.busy); end
            if (bus.done !== 1'b0) begin bad++; $display("FAIL idle_done k=%0d got=%b exp=0", k, bus.done); end
        end
    endtask

    task automatic test_load;
        logic [7:0] exp [8];
        exp = '{8'h5B, 8'h66, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h5B};
        do_load(7'd42, 7'd7, 2'd2);
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) tick();
            total += 2;
            if (bus.busy !== (k <= 7)) begin bad++; $display("FAIL load_busy k=%0d got=%b exp=%b", k, bus.busy, (k <= 7)); end
            if (bus.done !== (k == 8)) begin bad++; $display("FAIL load_done k=%0d got=%b exp=%b", k, bus.done, (k == 8)); end
        end
        capture();
        for (int i = 0; i < 8; i++) begin
            total++;
            if (cap[i] !== exp[i]) begin bad++; $display("FAIL digits_42_7 dig%0d got=%h exp=%h", i, cap[i], exp[i]); end
        end
    endtask

    task automatic test_range;
        logic [7:0] exp [8];
        logic seen;
        exp = '{8'h40, 8'h40, 8'h00, 8'h00, 8'h3F, 8'h00, 8'h00, 8'h00};
        do_load(7'd100, 7'd0, 2'd0);
        wait_done(12, seen);
        total++;
        if (seen !== 1'b1) begin bad++; $display("FAIL range_done_timeout got=%b exp=1", seen); end
        capture();
        for (int i = 0; i < 8; i++) begin
            total++;
            if (cap[i] !== exp[i]) begin bad++; $display("FAIL digits_100_0 dig%0d got=%h exp=%h", i, cap[i], exp[i]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp [8];
        exp = '{8'h4F, 8'h06, 8'h00, 8'h00, 8'h6F, 8'h6F, 8'h00, 8'h4F};
        do_load(7'd13, 7'd99, 2'd3);
        for (int k = 1; k <= 14; k++) begin
            if (k > 1) tick();
            if (k == 3) begin
                bus.val_a = 7'd55; bus.val_b = 7'd66; bus.lvl = 2'd1; bus.load = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            total++;
            if (bus.done !== (k == 8)) begin bad++; $display("FAIL b2b_done k=%0d got=%b exp=%b", k, bus.done, (k == 8)); end
        end
        capture();
        for (int i = 0; i < 8; i++) begin
            total++;
            if (cap[i] !== exp[i]) begin bad++; $display("FAIL digits_b2b dig%0d got=%h exp=%h", i, cap[i], exp[i]); end
        end
    endtask

    task automatic test_blink;
        int a_on, a_off, a_bad, b_on, b_off, b_bad;
        logic seen;
        do_load(7'd42, 7'd7, 2'd2);
        wait_done(12, seen);
        total++;
        if (seen !== 1'b1) begin bad++; $display("FAIL blink_done_timeout got=%b exp=1", seen); end
        for (int pass = 0; pass < 2; pass++) begin
            bus.blink_a = (pass == 0);
            bus.blink_b = (pass == 1);
            a_on = 0; a_off = 0; a_bad = 0; b_on = 0; b_off = 0; b_bad = 0;
            repeat (128) begin
                tick();
                case (bus_blk.dig)
                    8'hFE: if (bus_blk.seg === 8'h5B) a_on++; else if (bus_blk.seg === 8'h00) a_off++; else a_bad++;
                    8'hFD: if (bus_blk.seg === 8'h66) a_on++; else if (bus_blk.seg === 8'h00) a_off++; else a_bad++;
                    8'hEF: if (bus_blk.seg === 8'h07) b_on++; else if (bus_blk.seg === 8'h00) b_off++; else b_bad++;
                    8'hDF: if (bus_blk.seg !== 8'h00) b_bad++;
                    default: ;
                endcase
            end
            total += 4;
            if (a_bad + b_bad != 0) begin bad++; $display("FAIL blink_codes pass=%0d got=%0d bad exp=0", pass, a_bad + b_bad); end
            if (a_on == 0 || b_on == 0) begin bad++; $display("FAIL blink_visible pass=%0d got a_on=%0d b_on=%0d exp>0", pass, a_on, b_on); end
            if ((a_off != 0) !== (pass == 0)) begin bad++; $display("FAIL blink_a_off pass=%0d got=%0d exp_nonzero=%b", pass, a_off, (pass == 0)); end
            if ((b_off != 0) !== (pass == 1)) begin bad++; $display("FAIL blink_b_off pass=%0d got=%0d exp_nonzero=%b", pass, b_off, (pass == 1)); end
        end
        bus.blink_a = 1'b0;
        bus.blink_b = 1'b0;
    endtask

    task automatic test_reset_abort;
        logic [7:0] exp [8];
        logic seen;
        do_load(7'd13, 7'd99, 2'd3);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 5; k <= 12; k++) begin
            if (k > 5) tick();
            total += 2;
            if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy k=%0d got=%b exp=0", k, bus.busy); end
            if (bus.done !== 1'b0) begin bad++; $display("FAIL abort_done k=%0d got=%b exp=0", k, bus.done); end
        end
        capture();
        for (int i = 0; i < 8; i++) begin
            total++;
            if (cap[i] !== 8'h00) begin bad++; $display("FAIL abort_blank dig%0d got=%h exp=00", i, cap[i]); end
        end
        // load coincident with reset must be dropped
        bus.val_a = 7'd5; bus.val_b = 7'd5; bus.lvl = 2'd1;
        bus.load = 1'b1; rst = 1'b1;
        tick();
        bus.load = 1'b0; rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            total += 2;
            if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_load_busy k=%0d got=%b exp=0", k, bus.busy); end
            if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_load_done k=%0d got=%b exp=0", k, bus.done); end
            tick();
        end
        exp = '{8'h5B, 8'h66, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h5B};
        do_load(7'd42, 7'd7, 2'd2);
        wait_done(12, seen);
        total++;
        if (seen !== 1'b1) begin bad++; $display("FAIL reload_done_timeout got=%b exp=1", seen); end
        capture();
        for (int i = 0; i < 8; i++) begin
            total++;
            if (cap[i] !== exp[i]) begin bad++; $display("FAIL digits_reload dig%0d got=%h exp=%h", i, cap[i], exp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_range();
        test_back_to_back();
        test_blink();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
